// File: rtl/adim_motor_surucu_pkg.sv
// Shared definitions for the stepper motor driver: FSM state encodings,
// run command codes and the half-step coil phase table.
package adim_motor_surucu_pkg;

  // state | meaning
  // BOSTA | idle, coils off
  // ILERI | running forward, one step per prescaler period
  // GERI  | running reverse, one step per prescaler period
  // TUTMA | holding, coils energised on the last phase, no steps
  typedef enum logic [1:0] {
    BOSTA = 2'b00,
    ILERI = 2'b01,
    GERI  = 2'b10,
    TUTMA = 2'b11
  } durumT;

  localparam logic [1:0] KOMUT_ILERI = 2'b01;
  localparam logic [1:0] KOMUT_GERI  = 2'b10;

  // Coil drive {A,B,A',B'} per phase index; element 0 is the rightmost entry.
  // Odd entries are the two-coils-on positions used by full-step mode.
  localparam logic [7:0][3:0] FAZ_TABLOSU = {
    4'b1001,  // 7
    4'b0001,  // 6
    4'b0011,  // 5
    4'b0010,  // 4
    4'b0110,  // 3
    4'b0100,  // 2
    4'b1100,  // 1
    4'b1000   // 0
  };

  function automatic logic [3:0] fazBobin(input logic [2:0] fazIndeks);
    return FAZ_TABLOSU[fazIndeks];
  endfunction

endpackage

// File: rtl/komut_senkronlayici.sv
// Three-flop synchroniser for the asynchronous command bus with an
// agreement filter: the command output only follows the synchronised value
// when the last two stages agree, so a one-cycle glitch never reaches the FSM.
// The output is combinational from stages 2/3 so a stable change is visible
// right after the third edge, letting the FSM react on the fourth.
module komut_senkronlayici (
  input  logic       saatDarbesi,
  input  logic       sifirlama,
  input  logic [1:0] komut,
  output logic [1:0] komutFiltre
);

  logic [1:0] kademe1;
  logic [1:0] kademe2;
  logic [1:0] kademe3;
  logic [1:0] tutulan;

  // Synchroniser chain plus the last accepted command.
  always_ff @(posedge saatDarbesi or negedge sifirlama) begin
    if (!sifirlama) begin
      kademe1 <= 2'b00;
      kademe2 <= 2'b00;
      kademe3 <= 2'b00;
      tutulan <= 2'b00;
    end else begin
      kademe1 <= komut;
      kademe2 <= kademe1;
      kademe3 <= kademe2;
      tutulan <= komutFiltre;
    end
  end

  // Pass the synchronised command when stages agree, otherwise hold.
  always_comb begin
    komutFiltre = (kademe2 == kademe3) ? kademe3 : tutulan;
  end

endmodule

// File: rtl/adim_motor_surucu.sv
// Stepper motor driver: filtered direction command drives a four-state FSM,
// a prescaler paces the steps, and a phase index walks the coil table.
// Coil outputs, step pulse and position are all registered.
module adim_motor_surucu
  import adim_motor_surucu_pkg::*;
#(
  parameter int ADIM_BOLME   = 50000,
  parameter int YARIM_ADIM   = 0,
  parameter int TUTMA_SURESI = 100
) (
  input  logic               saatDarbesi,
  input  logic               sifirlama,
  input  logic [1:0]         komut,
  input  logic               etkin,
  output logic [3:0]         bobin,
  output logic               adimDarbesi,
  output logic signed [15:0] konum,
  output logic               mesgul
);

  localparam logic [15:0] SON_SAYIM = 16'(ADIM_BOLME - 1);
  localparam logic [7:0]  TUTMA_SON = 8'(TUTMA_SURESI - 1);
  localparam logic [2:0]  FAZ_ADIMI = (YARIM_ADIM != 0) ? 3'd1 : 3'd2;

  durumT       durum;
  durumT       sonrakiDurum;
  logic [1:0]  komutFiltre;
  logic [15:0] bolucu;
  logic [7:0]  tutmaSayac;
  logic [2:0]  faz;
  logic [2:0]  sonrakiFaz;
  logic [3:0]  sonrakiBobin;
  logic        sonSayim;
  logic        adim;
  logic        ileriKomut;
  logic        geriKomut;
  logic        calismaIzni;

  komut_senkronlayici uSenkron (
    .saatDarbesi (saatDarbesi),
    .sifirlama   (sifirlama),
    .komut       (komut),
    .komutFiltre (komutFiltre)
  );

  assign ileriKomut = (komutFiltre == KOMUT_ILERI);
  assign geriKomut  = (komutFiltre == KOMUT_GERI);
  assign sonSayim   = (bolucu == SON_SAYIM);
  // Leaving hold needs one complete step period; the terminal count that
  // closes the first period already counts as complete.
  assign calismaIzni = (tutmaSayac != 8'd0) || sonSayim;

  // State register.
  always_ff @(posedge saatDarbesi or negedge sifirlama) begin
    if (!sifirlama) begin
      durum <= BOSTA;
    end else begin
      durum <= sonrakiDurum;
    end
  end

  // Next-state logic; reversal always passes through hold, disable wins.
  always_comb begin
    sonrakiDurum = durum;
    case (durum)
      BOSTA: begin
        if (ileriKomut) begin
          sonrakiDurum = ILERI;
        end else if (geriKomut) begin
          sonrakiDurum = GERI;
        end
      end
      ILERI: begin
        if (!ileriKomut) begin
          sonrakiDurum = TUTMA;
        end
      end
      GERI: begin
        if (!geriKomut) begin
          sonrakiDurum = TUTMA;
        end
      end
      TUTMA: begin
        if (ileriKomut && calismaIzni) begin
          sonrakiDurum = ILERI;
        end else if (geriKomut && calismaIzni) begin
          sonrakiDurum = GERI;
        end else if (sonSayim && (tutmaSayac == TUTMA_SON)) begin
          sonrakiDurum = BOSTA;
        end
      end
      default: sonrakiDurum = BOSTA;
    endcase
    if (!etkin) begin
      sonrakiDurum = BOSTA;
    end
  end

  // Output decode: a step fires only on a terminal count that keeps the
  // run state, so a stop landing on the same edge suppresses the step.
  always_comb begin
    adim = ((durum == ILERI) || (durum == GERI)) && sonSayim && (sonrakiDurum == durum);
    sonrakiFaz = faz;
    if (adim) begin
      sonrakiFaz = (durum == ILERI) ? (faz + FAZ_ADIMI) : (faz - FAZ_ADIMI);
    end
    sonrakiBobin = (sonrakiDurum == BOSTA) ? 4'b0000 : fazBobin(sonrakiFaz);
    mesgul = (durum != BOSTA);
  end

  // Prescaler, hold-period counter, phase index and registered outputs.
  always_ff @(posedge saatDarbesi or negedge sifirlama) begin
    if (!sifirlama) begin
      bolucu      <= 16'd0;
      tutmaSayac  <= 8'd0;
      faz         <= 3'd1;
      bobin       <= 4'b0000;
      adimDarbesi <= 1'b0;
      konum       <= 16'sd0;
    end else begin
      if ((sonrakiDurum != durum) || sonSayim) begin
        bolucu <= 16'd0;
      end else begin
        bolucu <= bolucu + 16'd1;
      end
      if ((durum != TUTMA) || (sonrakiDurum != durum)) begin
        tutmaSayac <= 8'd0;
      end else if (sonSayim) begin
        tutmaSayac <= tutmaSayac + 8'd1;
      end
      faz         <= sonrakiFaz;
      bobin       <= sonrakiBobin;
      adimDarbesi <= adim;
      if (adim) begin
        konum <= (durum == ILERI) ? (konum + 16'sd1) : (konum - 16'sd1);
      end
    end
  end

endmodule

// File: tb/tb_adim_motor_surucu.sv
// Directed bench for adim_motor_surucu with a fast prescaler (4) and short
// hold (2 periods). A full-step and a half-step instance share all inputs.
module tb_adim_motor_surucu;
  import adim_motor_surucu_pkg::*;

  logic               saatDarbesi;
  logic               sifirlama;
  logic [1:0]         komut;
  logic               etkin;
  logic [3:0]         bobinF;
  logic               darbeF;
  logic signed [15:0] konumF;
  logic               mesgulF;
  logic [3:0]         bobinH;
  logic               darbeH;
  logic signed [15:0] konumH;
  logic               mesgulH;

  int hata;
  int toplam;

  logic [3:0] tabloIleri [4];
  logic [3:0] tabloGeriTam [4];
  logic [3:0] tabloGeriYarim [4];

  adim_motor_surucu #(.ADIM_BOLME(4), .YARIM_ADIM(0), .TUTMA_SURESI(2)) dutF (
    .saatDarbesi (saatDarbesi),
    .sifirlama   (sifirlama),
    .komut       (komut),
    .etkin       (etkin),
    .bobin       (bobinF),
    .adimDarbesi (darbeF),
    .konum       (konumF),
    .mesgul      (mesgulF)
  );

  adim_motor_surucu #(.ADIM_BOLME(4), .YARIM_ADIM(1), .TUTMA_SURESI(2)) dutH (
    .saatDarbesi (saatDarbesi),
    .sifirlama   (sifirlama),
    .komut       (komut),
    .etkin       (etkin),
    .bobin       (bobinH),
    .adimDarbesi (darbeH),
    .konum       (konumH),
    .mesgul      (mesgulH)
  );

  initial saatDarbesi = 1'b0;
  always #5 saatDarbesi = ~saatDarbesi;

  task automatic bekle(input int n);
    repeat (n) begin
      @(posedge saatDarbesi);
      #1;
    end
  endtask

  task automatic kontrol(input string etiket, input logic [15:0] gozlenen, input logic [15:0] beklenen);
    toplam++;
    assert (gozlenen === beklenen) else begin
      hata++;
      $error("FAIL %s: observed=%0h expected=%0h", etiket, gozlenen, beklenen);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end of the sequence");
    $fatal(1, "timeout");
  end

  initial begin
    hata = 0;
    toplam = 0;
    tabloIleri     = '{4'b0110, 4'b0011, 4'b1001, 4'b1100};
    tabloGeriTam   = '{4'b1001, 4'b0011, 4'b0110, 4'b1100};
    tabloGeriYarim = '{4'b1000, 4'b1001, 4'b0001, 4'b0011};

    // Reset state
    sifirlama = 1'b0;
    komut = 2'b00;
    etkin = 1'b1;
    bekle(3);
    kontrol("rst_bobin", 16'(bobinF), 16'h0);
    kontrol("rst_mesgul", 16'(mesgulF), 16'h0);
    kontrol("rst_konum", konumF, 16'h0);
    kontrol("rst_darbe", 16'(darbeF), 16'h0);
    kontrol("rst_faz", 16'(dutF.faz), 16'd1);

    // Full-step forward, command latency of four edges after release
    sifirlama = 1'b1;
    komut = 2'b01;
    bekle(3);
    kontrol("gecikme_3kenar", 16'(mesgulF), 16'h0);
    bekle(1);
    kontrol("giris_mesgul", 16'(mesgulF), 16'h1);
    kontrol("giris_bobin", 16'(bobinF), 16'b1100);
    kontrol("giris_konum", konumF, 16'h0);
    for (int i = 0; i < 4; i++) begin
      bekle(3);
      kontrol("ileri_arada_darbe", 16'(darbeF), 16'h0);
      bekle(1);
      kontrol("ileri_bobin", 16'(bobinF), 16'(tabloIleri[i]));
      kontrol("ileri_konum", konumF, 16'(i + 1));
      kontrol("ileri_darbe", 16'(darbeF), 16'h1);
    end

    // Stop lands on a terminal count: hold with no step, then timeout to idle
    komut = 2'b00;
    bekle(4);
    kontrol("dur_durum", 16'(dutF.durum), 16'(TUTMA));
    kontrol("dur_konum", konumF, 16'd4);
    kontrol("dur_darbe", 16'(darbeF), 16'h0);
    kontrol("dur_bobin", 16'(bobinF), 16'b1100);
    bekle(7);
    kontrol("tutma_bobin", 16'(bobinF), 16'b1100);
    kontrol("tutma_mesgul", 16'(mesgulF), 16'h1);
    bekle(1);
    kontrol("zamanasimi_mesgul", 16'(mesgulF), 16'h0);
    kontrol("zamanasimi_bobin", 16'(bobinF), 16'h0);
    kontrol("zamanasimi_konum", konumF, 16'd4);

    // Reversal goes through hold for a full step period
    komut = 2'b01;
    bekle(4);
    kontrol("ters_ileri_durum", 16'(dutF.durum), 16'(ILERI));
    bekle(4);
    kontrol("ters_ileri_konum", konumF, 16'd5);
    kontrol("ters_ileri_bobin", 16'(bobinF), 16'b0110);
    komut = 2'b10;
    bekle(4);
    kontrol("ters_tutma_durum", 16'(dutF.durum), 16'(TUTMA));
    kontrol("ters_tutma_konum", konumF, 16'd5);
    bekle(3);
    kontrol("ters_tutma_hala", 16'(dutF.durum), 16'(TUTMA));
    kontrol("ters_tutma_bobin", 16'(bobinF), 16'b0110);
    kontrol("ters_tutma_darbe", 16'(darbeF), 16'h0);
    bekle(1);
    kontrol("ters_geri_durum", 16'(dutF.durum), 16'(GERI));
    kontrol("ters_geri_bobin", 16'(bobinF), 16'b0110);
    bekle(4);
    kontrol("ters_geri_konum", konumF, 16'd4);
    kontrol("ters_geri_adim_bobin", 16'(bobinF), 16'b1100);
    kontrol("ters_geri_darbe", 16'(darbeF), 16'h1);

    // Reset between steps de-energises immediately
    bekle(2);
    sifirlama = 1'b0;
    #1;
    kontrol("rst_orta_bobin", 16'(bobinF), 16'h0);
    kontrol("rst_orta_konum", konumF, 16'h0);
    kontrol("rst_orta_mesgul", 16'(mesgulF), 16'h0);
    bekle(3);
    kontrol("rst_orta_darbe", 16'(darbeF), 16'h0);
    kontrol("rst_orta_konum2", konumF, 16'h0);

    // Half-step reverse from index 1 with wrap 0 -> 7
    sifirlama = 1'b1;
    bekle(3);
    kontrol("yarim_gecikme", 16'(mesgulH), 16'h0);
    bekle(1);
    kontrol("yarim_giris_bobin", 16'(bobinH), 16'b1100);
    for (int i = 0; i < 4; i++) begin
      bekle(4);
      kontrol("yarim_geri_bobin", 16'(bobinH), 16'(tabloGeriYarim[i]));
      kontrol("yarim_geri_konum", konumH, 16'(-(i + 1)));
      kontrol("tam_geri_bobin", 16'(bobinF), 16'(tabloGeriTam[i]));
      kontrol("tam_geri_konum", konumF, 16'(-(i + 1)));
      if (i == 1) kontrol("yarim_faz_sarma", 16'(dutH.faz), 16'd7);
    end

    // Enable drop mid-run: idle on the next edge, position and index kept
    etkin = 1'b0;
    bekle(1);
    kontrol("etkin_mesgul", 16'(mesgulH), 16'h0);
    kontrol("etkin_bobin", 16'(bobinH), 16'h0);
    kontrol("etkin_konum", konumH, 16'(-4));
    kontrol("etkin_faz", 16'(dutH.faz), 16'd5);

    // One-cycle command glitch is filtered out
    komut = 2'b00;
    bekle(5);
    etkin = 1'b1;
    bekle(5);
    komut = 2'b01;
    bekle(1);
    komut = 2'b00;
    bekle(10);
    kontrol("glitch_mesgul", 16'(mesgulF), 16'h0);
    kontrol("glitch_bobin", 16'(bobinF), 16'h0);
    kontrol("glitch_durum", 16'(dutF.durum), 16'(BOSTA));

    $display("Result: errors=%0d of %0d checks", hata, toplam);
    $finish;
  end

endmodule
